// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared types and defaults for the DCT multiply-accumulate sequencer.
//   TAPS_DEFAULT      points per dot product
//   MULT_LAT_DEFAULT  cycles from multiplier operands to mult_res at the accumulator
//   coef_idx_t        tap index at the default TAPS
//   dct_row_t         coefficient row selector
//   seq_state_t       sequencer FSM states
//   mac_ctl_t         control word carried down the multiplier-latency delay line
// -----------------------------------------------------------------------------
package dct_pkg;

    localparam int TAPS_DEFAULT     = 8;
    localparam int MULT_LAT_DEFAULT = 2;
    localparam int CW_DEFAULT       = $clog2(TAPS_DEFAULT);

    typedef logic [CW_DEFAULT-1:0] coef_idx_t;
    typedef logic [2:0]            dct_row_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_ACC  = 1'b1
    } seq_state_t;

    // en: multiplier operands valid; first/last: tap 0 / tap TAPS-1 of a product;
    // row: coefficient row the product belongs to.
    typedef struct packed {
        logic     en;
        logic     first;
        logic     last;
        dct_row_t row;
    } mac_ctl_t;

endpackage

// File: rtl/dct_ctl_delay.sv
// -----------------------------------------------------------------------------
// dct_ctl_delay
// DEPTH-stage shift register of mac_ctl_t. Re-times the multiplier-side control
// word so it arrives at the accumulator together with mult_res.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous clear of every stage, active-high (overrides i_ena)
//   i_ena  clock enable; 0 holds every stage
//   i_ctl  control word entering the multiplier stage
//   o_ctl  control word DEPTH cycles later
// -----------------------------------------------------------------------------
module dct_ctl_delay
    import dct_pkg::*;
#(
    parameter int DEPTH = MULT_LAT_DEFAULT
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_ena,
    input  mac_ctl_t i_ctl,
    output mac_ctl_t o_ctl
);

    mac_ctl_t r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_ena) begin
            r_pipe[0] <= i_ctl;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_ctl = r_pipe[DEPTH-1];

endmodule

// File: rtl/dct_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dct_mac_sequencer
// Sequences one DCT multiply-accumulate unit through a TAPS-point dot product:
// steps the tap index, raises the multiplier-stage enable, and produces a
// MULT_LAT-delayed copy of that control for the accumulator plus a result flag.
// Back-to-back products run without a bubble.
// Parameters:
//   TAPS      points per dot product (power of 2, >= 2)
//   MULT_LAT  multiplier latency to the accumulator input (>= 1)
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous reset, active-high (overrides i_ena)
//   i_ena        global clock enable; 0 freezes all state
//   i_start      dot-product request, taken when i_start & o_ready & i_ena
//   i_row_sel    coefficient row of the request, latched when taken
//   o_ready      a request can be taken this cycle
//   o_coef_row   latched row to the coefficient ROM
//   o_coef_idx   tap index to the sample mux and coefficient ROM
//   o_mac_en     multiplier operands valid
//   o_acc_clr    accumulator loads mult_res instead of adding (first tap)
//   o_acc_en     accumulator updates this cycle
//   o_res_valid  accumulator holds a complete sum (one result per pulse)
//   o_res_row    row of the sum flagged by o_res_valid
// -----------------------------------------------------------------------------
module dct_mac_sequencer
    import dct_pkg::*;
#(
    parameter  int TAPS     = TAPS_DEFAULT,
    parameter  int MULT_LAT = MULT_LAT_DEFAULT,
    localparam int CW       = $clog2(TAPS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ena,
    input  logic          i_start,
    input  dct_row_t      i_row_sel,
    output logic          o_ready,
    output dct_row_t      o_coef_row,
    output logic [CW-1:0] o_coef_idx,
    output logic          o_mac_en,
    output logic          o_acc_clr,
    output logic          o_acc_en,
    output logic          o_res_valid,
    output dct_row_t      o_res_row
);

    localparam logic [CW-1:0] LAST_IDX = CW'(TAPS - 1);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;
    logic [CW-1:0] r_idx;
    dct_row_t      r_coef_row;
    logic          r_res_valid;
    dct_row_t      r_res_row;

    logic          w_last_tap;
    logic          w_ready;
    logic          w_mac_en;
    logic          w_accept;
    mac_ctl_t      w_ctl_in;
    mac_ctl_t      w_ctl_dly;

    assign w_last_tap = (r_idx == LAST_IDX);
    // ena is folded in so a request seen during a stall is simply dropped.
    assign w_accept   = i_start & w_ready & i_ena;

    // ---- FSM: state register ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEQ_IDLE;
        end else if (i_ena) begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SEQ_ACC;
                end
            end
            SEQ_ACC: begin
                // A request taken on the last tap keeps the FSM in ACC.
                if (w_last_tap && !w_accept) begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            default: w_state_nxt = SEQ_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        w_ready  = 1'b0;
        w_mac_en = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                w_ready = 1'b1;
            end
            SEQ_ACC: begin
                w_mac_en = 1'b1;
                w_ready  = w_last_tap;
            end
            default: begin
                w_ready  = 1'b0;
                w_mac_en = 1'b0;
            end
        endcase
    end

    // Tap index: runs only in ACC. Leaving the last tap always returns to 0,
    // whether the FSM goes back to IDLE or starts the next product directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx <= '0;
        end else if (i_ena && r_state == SEQ_ACC) begin
            r_idx <= w_last_tap ? '0 : r_idx + 1'b1;
        end
    end

    // Row latch: held until the next accepted request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_coef_row <= '0;
        end else if (w_accept) begin
            r_coef_row <= i_row_sel;
        end
    end

    // ---- multiplier stage -> accumulator stage (MULT_LAT cycles) ----
    assign w_ctl_in.en    = w_mac_en;
    assign w_ctl_in.first = w_mac_en & (r_idx == '0);
    assign w_ctl_in.last  = w_mac_en & w_last_tap;
    assign w_ctl_in.row   = r_coef_row;

    dct_ctl_delay #(
        .DEPTH (MULT_LAT)
    ) u_ctl_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_ena (i_ena),
        .i_ctl (w_ctl_in),
        .o_ctl (w_ctl_dly)
    );

    // ---- accumulator stage -> result flag ----
    // The sum is complete one cycle after the last tap is added, which is the
    // same cycle a back-to-back product's first tap reloads the accumulator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_row   <= '0;
        end else if (i_ena) begin
            r_res_valid <= w_ctl_dly.last;
            if (w_ctl_dly.last) begin
                r_res_row <= w_ctl_dly.row;
            end
        end
    end

    assign o_ready     = w_ready;
    assign o_coef_row  = r_coef_row;
    assign o_coef_idx  = r_idx;
    assign o_mac_en    = w_mac_en;
    assign o_acc_clr   = w_ctl_dly.first;
    assign o_acc_en    = w_ctl_dly.en;
    assign o_res_valid = r_res_valid;
    assign o_res_row   = r_res_row;

endmodule
